clock_divider: RTL and testbench

Parameterised integer clock divider. Turns the 50 MHz board clock into a slower square wave, e.g. DIVISOR = 50 for the 1 MHz timebase that drives the ultrasonic trigger pulse counter. It also provides a single-cycle strobe in the source clock domain, so downstream logic can run as a clock enable instead of on a derived clock.

---
 rtl/clock_divider_pkg.sv | 14 +
 rtl/clock_divider.sv | 63 ++++++
 tb/tb_clock_divider.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/clock_divider_pkg.sv
// clock_divider_pkg
//   Shared constants and helpers for the clock_divider block.
//   MIN_DIVISOR : smallest legal division ratio.
//   high_count  : number of source cycles the divided clock spends high.
package clock_divider_pkg;

  localparam int unsigned MIN_DIVISOR = 2;

  // High phase is floor(divisor/2); odd ratios get the extra cycle in the low phase.
  function automatic int unsigned high_count(input int unsigned divisor);
    return divisor / 2;
  endfunction

endpackage

// File: rtl/clock_divider.sv
// clock_divider
//   Parameterised integer clock divider with a source-domain strobe.
//   Output period is DIVISOR ClockIn cycles; ClockOut is high for
//   floor(DIVISOR/2) cycles and low for the remainder.
//
//   Parameters:
//     DIVISOR  division ratio, integer >= 2
//     CNT_W    counter width, derived from DIVISOR (do not override)
//
//   Ports:
//     ClockIn   in   source clock, all logic on its rising edge
//     ResetN    in   synchronous active-low reset
//     Enable    in   count enable; low freezes the divider state
//     ClockOut  out  divided clock, registered
//     TickOut   out  one-cycle strobe, high in the cycle ClockOut rises
module clock_divider
  import clock_divider_pkg::*;
#(
  parameter int unsigned DIVISOR = 50,
  parameter int unsigned CNT_W   = $clog2(DIVISOR)
) (
  input  logic ClockIn,
  input  logic ResetN,
  input  logic Enable,
  output logic ClockOut,
  output logic TickOut
);

  if (DIVISOR < MIN_DIVISOR) begin : g_bad_divisor
    $error("clock_divider: DIVISOR must be an integer >= 2");
  end

  localparam int unsigned HIGH = high_count(DIVISOR);

  // Compare points sized to the counter so the wrap is an explicit compare,
  // independent of whether DIVISOR is a power of two.
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIVISOR - 1);
  localparam logic [CNT_W-1:0] CNT_CLEAR = CNT_W'(HIGH - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge ClockIn) begin
    if (!ResetN) begin
      cnt      <= '0;
      ClockOut <= 1'b0;
      TickOut  <= 1'b0;
    end else if (!Enable) begin
      // Counter and ClockOut hold; the strobe must never fire while frozen.
      TickOut <= 1'b0;
    end else if (cnt == CNT_LAST) begin
      cnt      <= '0;
      ClockOut <= 1'b1;
      TickOut  <= 1'b1;
    end else begin
      cnt     <= cnt + CNT_W'(1);
      TickOut <= 1'b0;
      if (cnt == CNT_CLEAR) begin
        ClockOut <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_clock_divider.sv
// tb_clock_divider
//   Directed bench for clock_divider at DIVISOR = 50, 5 and 2.
//   After n enabled edges since reset release, the expected ClockOut is
//   high when n >= D and (n mod D) < floor(D/2); TickOut is high when
//   n >= D and (n mod D) == 0.
module tb_clock_divider;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rn50, rn5, rn2, en50;
  logic en_on;
  logic co50, tk50, co5, tk5, co2, tk2;

  int unsigned errors = 0;
  int unsigned checks = 0;

  clock_divider #(.DIVISOR(50)) u_div50 (
    .ClockIn(clk), .ResetN(rn50), .Enable(en50), .ClockOut(co50), .TickOut(tk50)
  );
  clock_divider #(.DIVISOR(5)) u_div5 (
    .ClockIn(clk), .ResetN(rn5), .Enable(en_on), .ClockOut(co5), .TickOut(tk5)
  );
  clock_divider #(.DIVISOR(2)) u_div2 (
    .ClockIn(clk), .ResetN(rn2), .Enable(en_on), .ClockOut(co2), .TickOut(tk2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one rising edge; inputs change and outputs are sampled 1 ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic exp_clk(input int d, input int n);
    return (n >= d) && ((n % d) < (d / 2));
  endfunction

  function automatic logic exp_tick(input int d, input int n);
    return (n >= d) && ((n % d) == 0);
  endfunction

  initial begin
    int first_rise;
    int last_rise;
    int period_cnt;
    logic prev;
    int run;
    logic first_low;

    en_on = 1'b1;
    en50  = 1'b1;
    rn50  = 1'b0;
    rn5   = 1'b0;
    rn2   = 1'b0;
    repeat (3) step();

    check("rst_d50_clk",  co50, 1'b0);
    check("rst_d50_tick", tk50, 1'b0);
    check("rst_d5_clk",   co5,  1'b0);
    check("rst_d5_tick",  tk5,  1'b0);
    check("rst_d2_clk",   co2,  1'b0);
    check("rst_d2_tick",  tk2,  1'b0);

    // Release all three together and run past five DIVISOR=50 rises.
    rn50 = 1'b1;
    rn5  = 1'b1;
    rn2  = 1'b1;
    first_rise = -1;
    last_rise  = -1;
    period_cnt = 0;
    prev       = 1'b0;
    for (int n = 1; n <= 260; n++) begin
      step();
      check("d50_clk",  co50, exp_clk(50, n));
      check("d50_tick", tk50, exp_tick(50, n));
      check("d5_clk",   co5,  exp_clk(5, n));
      check("d5_tick",  tk5,  exp_tick(5, n));
      check("d2_clk",   co2,  exp_clk(2, n));
      check("d2_tick",  tk2,  exp_tick(2, n));
      if (co50 && !prev) begin
        if (first_rise < 0) begin
          first_rise = n;
        end else begin
          check("d50_period", n - last_rise, 50);
          period_cnt++;
        end
        last_rise = n;
      end
      prev = co50;
    end
    check("d50_first_rise", first_rise, 50);
    check("d50_period_count", period_cnt, 4);

    // Edge 260 left the DIVISOR=50 counter at 10 with ClockOut high.
    check("d50_pre_reset_high", co50, 1'b1);
    rn50 = 1'b0;
    step();
    check("d50_midreset_clk",  co50, 1'b0);
    check("d50_midreset_tick", tk50, 1'b0);
    rn50 = 1'b1;

    first_rise = -1;
    prev       = 1'b0;
    for (int m = 1; m <= 80; m++) begin
      step();
      check("d50r_clk",  co50, exp_clk(50, m));
      check("d50r_tick", tk50, exp_tick(50, m));
      if (co50 && !prev && first_rise < 0) first_rise = m;
      prev = co50;
    end
    check("d50r_first_rise", first_rise, 50);

    // Edge 80 after release is 6 edges into the low phase (fell on edge 75).
    run       = 6;
    prev      = co50;
    first_low = 1'b1;
    en50 = 1'b0;
    for (int k = 0; k < 7; k++) begin
      step();
      check("d50_frozen_clk",  co50, 1'b0);
      check("d50_frozen_tick", tk50, 1'b0);
      run++;
    end
    en50 = 1'b1;

    for (int m = 81; m <= 200; m++) begin
      step();
      check("d50e_clk",  co50, exp_clk(50, m));
      check("d50e_tick", tk50, exp_tick(50, m));
      if (co50 == prev) begin
        run++;
      end else begin
        if (co50) begin
          check(first_low ? "d50_stretched_low" : "d50_low_len", run, first_low ? 32 : 25);
          first_low = 1'b0;
        end else begin
          check("d50_high_len", run, 25);
        end
        run = 1;
      end
      prev = co50;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
